mux_piso_sequencer: RTL and testbench

- Upstream sequencer and serializer for the 8:1 multiplexer stage.
- Accepts a parallel word over a valid/ready handshake and holds it in a register that is the mux data input.
- Steps a select counter through every bit position and emits one serial bit per accepted output beat, with frame markers.
- Contains the select-driven 8:1 selection internally and exports the select lines (s1 = MSB) so an external mux instance can be driven in lockstep.

---
 rtl/mux_piso_if.sv | 32 +++
 rtl/mux_piso_sequencer.sv | 83 ++++++++
 tb/tb_mux_piso_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_piso_if.sv
// Parallel-in / serial-out handshake bundle for mux_piso_sequencer.
// master = word producer and serial consumer, slave = the sequencer itself.
interface mux_piso_if #(
  parameter int SEL_W = 3
);
  localparam int WIDTH = 2 ** SEL_W;

  // Valid/ready rule on both channels: a transfer happens on a rising clk edge
  // where valid && ready are both high; the sender holds its data stable while
  // valid is high and ready is low, and ready may depend on the other channel.
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic             ser_bit;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_first;
  logic             ser_last;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, sel, ser_bit, ser_valid, ser_first, ser_last, busy, dbg_state
  );

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, sel, ser_bit, ser_valid, ser_first, ser_last, busy, dbg_state
  );
endinterface

// File: rtl/mux_piso_sequencer.sv
// Word-in, bit-out sequencer driving the select lines of an 8:1 mux stage.
// Define MUX_PISO_PARITY_EN to append an even-parity beat to every frame.
module mux_piso_sequencer #(
  parameter int SEL_W     = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic       clk,
  input logic       rst_n,
  mux_piso_if.slave bus
);
  localparam int WIDTH = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? SEL_W'(WIDTH - 1) : '0;
  localparam logic [SEL_W-1:0] SEL_END   = MSB_FIRST ? '0 : SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);
  localparam logic [SEL_W:0]   BEAT_ONE  = (SEL_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef MUX_PISO_PARITY_EN
    , PAR = 2'd2
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] word_reg;
  logic [SEL_W-1:0] sel_cnt;
  logic [SEL_W:0]   beat_cnt;

  logic at_end;
  logic final_beat;
  logic beat_fire;
  logic load;

  assign at_end = (state == SHIFT) && (sel_cnt == SEL_END);

  // The final beat of a frame is where the next word may be accepted.
`ifdef MUX_PISO_PARITY_EN
  assign final_beat  = (state == PAR);
  assign bus.ser_bit = (state == PAR) ? ^word_reg : word_reg[sel_cnt];
`else
  assign final_beat  = at_end;
  assign bus.ser_bit = word_reg[sel_cnt];
`endif

  assign bus.in_ready  = (state == IDLE) || (final_beat && bus.ser_ready);
  assign bus.ser_valid = (state != IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.sel       = sel_cnt;
  assign bus.ser_first = (state == SHIFT) && (beat_cnt == '0);
  assign bus.ser_last  = final_beat;
  assign bus.dbg_state = state;

  assign beat_fire = bus.ser_valid && bus.ser_ready;
  assign load      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_reg <= '0;
      sel_cnt  <= SEL_START;
      beat_cnt <= '0;
    end else if (load) begin
      // Covers both a load from IDLE and a back-to-back load on the final beat.
      word_reg <= bus.in_data;
      sel_cnt  <= SEL_START;
      beat_cnt <= '0;
      state    <= SHIFT;
    end else if (beat_fire) begin
      if (final_beat) begin
        state <= IDLE;
`ifdef MUX_PISO_PARITY_EN
      end else if (at_end) begin
        state    <= PAR;
        beat_cnt <= beat_cnt + BEAT_ONE;
`endif
      end else begin
        sel_cnt  <= MSB_FIRST ? (sel_cnt - SEL_ONE) : (sel_cnt + SEL_ONE);
        beat_cnt <= beat_cnt + BEAT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_mux_piso_sequencer.sv
// Bench for mux_piso_sequencer: an LSB-first and an MSB-first instance share
// one stimulus stream and are both compared against a beat-index model.
module tb_mux_piso_sequencer;
  localparam int SEL_W = 3;
  localparam int W     = 8;
`ifdef MUX_PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int N = W + PAR;

  // ---------------- clock / reset / shared stimulus ----------------
  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       in_valid  = 1'b0;
  logic       ser_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_piso_if #(.SEL_W(SEL_W)) if0 ();
  mux_piso_if #(.SEL_W(SEL_W)) if1 ();

  assign if0.in_data   = in_data;
  assign if0.in_valid  = in_valid;
  assign if0.ser_ready = ser_ready;
  assign if1.in_data   = in_data;
  assign if1.in_valid  = in_valid;
  assign if1.ser_ready = ser_ready;

  mux_piso_sequencer #(.SEL_W(SEL_W), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  mux_piso_sequencer #(.SEL_W(SEL_W), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  // ---------------- reference model: frame = N beats indexed by k ----------------
  bit         m_active     = 1'b0;
  logic [7:0] m_word       = 8'h00;
  int         m_k          = 0;
  bit         m_idle_start = 1'b1;

  function automatic logic m_ready();
    return !m_active || ((m_k == N - 1) && ser_ready);
  endfunction

  function automatic logic [2:0] m_sel(input bit msb);
    if (m_active && m_k < W) return msb ? 3'(W - 1 - m_k) : 3'(m_k);
    if (m_active || !m_idle_start) return msb ? 3'd0 : 3'd7;
    return msb ? 3'd7 : 3'd0;
  endfunction

  function automatic logic m_bit(input bit msb);
    if (m_k >= W) return ^m_word;
    return msb ? m_word[W - 1 - m_k] : m_word[m_k];
  endfunction

  task automatic m_update();
    if (!rst_n) begin
      m_active     = 1'b0;
      m_idle_start = 1'b1;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active = 1'b1;
        m_word   = in_data;
        m_k      = 0;
      end
    end else if (ser_ready) begin
      if (m_k == N - 1) begin
        if (in_valid) begin
          m_word = in_data;
          m_k    = 0;
        end else begin
          m_active     = 1'b0;
          m_idle_start = 1'b0;
        end
      end else begin
        m_k++;
      end
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_one(input string t, input bit msb, input logic rdy, input logic v,
                         input logic bz, input logic b, input logic [2:0] s,
                         input logic f, input logic l);
    chk({t, ".in_ready"}, rdy, m_ready());
    chk({t, ".ser_valid"}, v, m_active);
    chk({t, ".busy"}, bz, m_active);
    chk({t, ".sel"}, s, m_sel(msb));
    chk({t, ".ser_first"}, f, m_active && (m_k == 0));
    chk({t, ".ser_last"}, l, m_active && (m_k == N - 1));
    if (m_active) chk({t, ".ser_bit"}, b, m_bit(msb));
  endtask

  task automatic cyc_check();
    @(negedge clk);
    cmp_one("m0", 1'b0, if0.in_ready, if0.ser_valid, if0.busy, if0.ser_bit, if0.sel,
            if0.ser_first, if0.ser_last);
    cmp_one("m1", 1'b1, if1.in_ready, if1.ser_valid, if1.busy, if1.ser_bit, if1.sel,
            if1.ser_first, if1.ser_last);
  endtask

  task automatic cyc_clock();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic drive(input logic rn, input logic v, input logic [7:0] d, input logic r);
    rst_n     = rn;
    in_valid  = v;
    in_data   = d;
    ser_ready = r;
  endtask

  task automatic drain();
    int n = 0;
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    while (if0.busy && n < 40) begin
      cyc_check();
      cyc_clock();
      n++;
    end
    chk("drain_timeout", (n >= 40), 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       rn, v;
    logic [7:0] d;
    logic       r, c;
    logic       e_valid, e_ready, e_first, e_last;
    logic [2:0] e_sel0;
    logic       e_bit0;
    logic [2:0] e_sel1;
    logic       e_bit1;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rn, input logic v, input logic [7:0] d,
                              input logic r, input logic c, input logic ev,
                              input logic er, input logic ef, input logic el,
                              input logic [2:0] s0, input logic b0,
                              input logic [2:0] s1, input logic b1);
    vec_t x;
    x = '{rn, v, d, r, c, ev, er, ef, el, s0, b0, s1, b1};
    vecs.push_back(x);
  endfunction

  initial begin
    // rst, v, data, rdy, chk | valid, in_ready, first, last, sel0, bit0, sel1, bit1
    add(0, 0, 8'h00, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    add(1, 1, 8'hCD, 1, 1,  0, 1, 0, 0,  0, 0, 7, 0);
    add(1, 0, 8'h00, 1, 1,  1, 0, 1, 0,  0, 1, 7, 1);
    add(1, 0, 8'h33, 1, 1,  1, 0, 0, 0,  1, 0, 6, 1);
    add(1, 0, 8'h00, 1, 1,  1, 0, 0, 0,  2, 1, 5, 0);
    add(1, 0, 8'hFF, 1, 1,  1, 0, 0, 0,  3, 1, 4, 0);
    add(1, 0, 8'h00, 1, 1,  1, 0, 0, 0,  4, 0, 3, 1);
    add(1, 0, 8'h00, 1, 1,  1, 0, 0, 0,  5, 0, 2, 1);
    add(1, 0, 8'h00, 1, 1,  1, 0, 0, 0,  6, 1, 1, 0);
    add(1, 0, 8'h00, 1, 1,  1, PAR == 0, 0, PAR == 0,  7, 1, 0, 1);
    if (PAR != 0) add(1, 0, 8'h00, 1, 1,  1, 1, 0, 1,  7, 1, 0, 1);
    add(1, 0, 8'h00, 1, 1,  0, 1, 0, 0,  7, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rn, vecs[i].v, vecs[i].d, vecs[i].r);
      if (vecs[i].c) begin
        cyc_check();
        chk("tbl.ser_valid", if0.ser_valid, vecs[i].e_valid);
        chk("tbl.in_ready", if0.in_ready, vecs[i].e_ready);
        chk("tbl.ser_first", if0.ser_first, vecs[i].e_first);
        chk("tbl.ser_last", if0.ser_last, vecs[i].e_last);
        chk("tbl.sel0", if0.sel, vecs[i].e_sel0);
        chk("tbl.sel1", if1.sel, vecs[i].e_sel1);
        if (vecs[i].e_valid) begin
          chk("tbl.bit0", if0.ser_bit, vecs[i].e_bit0);
          chk("tbl.bit1", if1.ser_bit, vecs[i].e_bit1);
        end
      end
      cyc_clock();
    end

    // Backpressure at sel=3: everything holds for three stalled cycles.
    drive(1, 1, 8'hCD, 1); cyc_check(); cyc_clock();
    drive(1, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin cyc_check(); cyc_clock(); end
    drive(1, 0, 8'h5A, 0);
    for (int i = 0; i < 3; i++) begin
      cyc_check();
      chk("bp.sel", if0.sel, 3'd3);
      chk("bp.ser_bit", if0.ser_bit, 1'b1);
      chk("bp.ser_valid", if0.ser_valid, 1'b1);
      cyc_clock();
    end
    drain();

    // Back-to-back: next word accepted on the final beat, no bubble.
    drive(1, 1, 8'hCD, 1); cyc_check(); cyc_clock();
    drive(1, 0, 8'h00, 1);
    for (int i = 0; i < N - 1; i++) begin cyc_check(); cyc_clock(); end
    drive(1, 1, 8'hA5, 1);
    cyc_check();
    chk("b2b.in_ready", if0.in_ready, 1'b1);
    chk("b2b.ser_last", if0.ser_last, 1'b1);
    cyc_clock();
    drive(1, 0, 8'h00, 1);
    cyc_check();
    chk("b2b.ser_valid", if0.ser_valid, 1'b1);
    chk("b2b.ser_first", if0.ser_first, 1'b1);
    chk("b2b.ser_bit", if0.ser_bit, 1'b1);
    chk("b2b.sel", if0.sel, 3'd0);
    chk("b2b.ser_bit1", if1.ser_bit, 1'b1);
    cyc_clock();
    drain();

    // Reset at beat 4 discards the frame; a following 8'hFF gives all ones.
    drive(1, 1, 8'hCD, 1); cyc_check(); cyc_clock();
    drive(1, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin cyc_check(); cyc_clock(); end
    drive(0, 0, 8'h00, 1); cyc_clock();
    drive(1, 0, 8'h00, 1);
    cyc_check();
    chk("rst.ser_valid", if0.ser_valid, 1'b0);
    chk("rst.busy", if0.busy, 1'b0);
    chk("rst.sel", if0.sel, 3'd0);
    chk("rst.sel1", if1.sel, 3'd7);
    cyc_clock();
    drive(1, 1, 8'hFF, 1); cyc_check(); cyc_clock();
    drive(1, 0, 8'h00, 1);
    for (int i = 0; i < W; i++) begin
      cyc_check();
      chk("ff.ser_bit", if0.ser_bit, 1'b1);
      chk("ff.ser_bit1", if1.ser_bit, 1'b1);
      cyc_clock();
    end
    drain();

    // Randomized traffic with occasional resets and noisy in_data.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 3) != 0));
      cyc_check();
      cyc_clock();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
